// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator (horizontal + vertical counters)
// Ports: clk_pix pixel clock; clr_25MHz async active-high reset; en pixel clock-enable;
//        hsync/vsync sync levels per HS_POL/VS_POL; active visible-region flag;
//        x/y pixel coordinates (0 outside the visible region); line_end last-pixel strobe;
//        frame_start first-pixel strobe; frame_cnt 16-bit frame counter (only with
//        VGA_TIMING_FRAME_CNT_EN defined).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 12
) (
    input  logic             clk_pix,
    input  logic             clr_25MHz,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_end,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_S   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_S   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    if (H_TOTAL - 1 >= (1 << CNT_W) || V_TOTAL - 1 >= (1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic h_wrap, hs_nxt, vs_nxt, act_nxt, fs_nxt;
    // Outputs are registered from the post-increment counter values so that every
    // output describes the same pixel as the counters it is registered with.
    always_comb begin
        h_wrap  = h_cnt == H_LAST;
        h_nxt   = h_wrap ? '0 : h_cnt + CNT_W'(1);
        v_nxt   = h_wrap ? (v_cnt == V_LAST ? '0 : v_cnt + CNT_W'(1)) : v_cnt;
        hs_nxt  = (h_nxt >= HS_S && h_nxt < HS_E) ? HS_POL : ~HS_POL;
        vs_nxt  = (v_nxt >= VS_S && v_nxt < VS_E) ? VS_POL : ~VS_POL;
        act_nxt = h_nxt < H_ACT && v_nxt < V_ACT;
        fs_nxt  = h_nxt == '0 && v_nxt == '0;
    end
    always_ff @(posedge clk_pix or posedge clr_25MHz) begin
        if (clr_25MHz) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                h_cnt       <= h_nxt;
                v_cnt       <= v_nxt;
                hsync       <= hs_nxt;
                vsync       <= vs_nxt;
                active      <= act_nxt;
                x           <= act_nxt ? h_nxt : '0;
                y           <= act_nxt ? v_nxt : '0;
                line_end    <= h_nxt == H_LAST;
                frame_start <= fs_nxt;
            end
        end
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk_pix or posedge clr_25MHz) begin
        if (clr_25MHz)
            frame_cnt <= '0;
        else if (en && fs_nxt)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Horizontal and vertical counters live in one block.
- Produces sync, blanking, pixel coordinates and line/frame strobes for the pixel pipeline and framebuffer reader.
- Successor to the fixed single-axis horizontal counter. Adds programmable porches, sync polarity, a pixel clock-enable and a vertical axis.
- Defaults give 640x480@60 on a 25 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync
- VS_POL, 0, asserted level of vsync
- CNT_W, 12, width of counters and coordinate outputs

Ports:
- clk_pix  in  1  pixel clock
- clr_25MHz  in  1  reset, asynchronous, active-high
- en  in  1  pixel clock-enable; counters advance only on edges with en=1
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- active  out  1  high while the pixel is inside the visible region
- x  out  CNT_W  column; h_cnt when active, else 0
- y  out  CNT_W  row; v_cnt when active, else 0
- line_end  out  1  one-clock strobe, last pixel of a line
- frame_start  out  1  one-clock strobe, first pixel of a frame

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525). Elaboration error if H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W, or if any porch/sync parameter is 0.
- Region order per axis: active, front porch, sync, back porch.
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; vsync spans whole lines.
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- Counters:
  - Reset state is h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 (last pixel of a frame).
  - On each edge with en=1: h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0 on that same edge.
- All outputs are registered and mutually aligned: each output reflects the counter state it is registered with. No combinational path from en to outputs.
- Reset (async): hsync=~HS_POL, vsync=~VS_POL, active=0, x=0, y=0, line_end=0, frame_start=0.
- First enabled edge after reset release gives h=0,v=0: active=1, x=0, y=0, frame_start=1.
- Strobes:
  - line_end is 1 for exactly one clock after the enabled edge that reaches h_cnt=H_TOTAL-1.
  - frame_start is 1 for exactly one clock after the enabled edge that reaches (0,0).
  - Both clear on the next clock edge regardless of en.
- en=0: counters and level outputs (hsync, vsync, active, x, y) hold; strobes drop to 0.
- Reset mid-frame: outputs go idle immediately; the raster restarts from (0,0) on the first enabled edge after release.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- When defined: adds output frame_cnt [15:0].
  - Reset value 0.
  - Increments on the same edge that raises frame_start; wraps 65535->0.
  - Used for blink and animation timing.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Default params, en=1: after release, 1st edge -> x=0,y=0,active=1,frame_start=1. hsync low exactly when h in 656..751 (96 clocks). line_end at h=799. The next clock shows y=1, x=0.
- Full frame, en=1: exactly 420000 clocks between consecutive frame_start pulses. vsync low for lines 490..491 (1600 clocks). active high 307200 clocks per frame.
- en alternating 1/0:
  - Line period is 1600 clocks and outputs hold on en=0 cycles.
  - line_end and frame_start are each one clock wide.
- Reset at h=300,v=100: hsync=1, vsync=1, active=0 at once. First enabled edge after release -> (0,0), frame_start=1.
- Small params H 4/1/2/1, V 3/1/1/1, HS_POL=1, VS_POL=1:
  - H_TOTAL=8, V_TOTAL=6, frame period 48 clocks.
  - hsync high at h=5,6; vsync high during line 4.
- With VGA_TIMING_FRAME_CNT_EN: frame_cnt=1 after the first frame_start and 3 after three frames. Forced through 65535 -> wraps to 0.
